tile_renderer: RTL and testbench

Frame renderer that sits directly downstream of the game logic engine. Once per logic cycle it snapshots the engine's playfield state (`yoffset`, `keys`, `num_hit`) and rasterises the full 160x120 playfield into the VGA adapter. It emits one pixel write per clock and signals completion so the engine's sleep/update loop can proceed.

---
 rtl/piano_tiles_pkg.sv | 33 +++
 rtl/tile_colour_lookup.sv | 53 +++++
 rtl/tile_renderer.sv | 102 ++++++++++
 tb/tb_tile_renderer.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/piano_tiles_pkg.sv
// Shared piano-tiles constants, colours, renderer FSM states and the playfield snapshot.
// The logic engine uses the same hitbox and tile-height values.
package piano_tiles_pkg;

    localparam int SCREEN_WIDTH  = 160;
    localparam int SCREEN_HEIGHT = 120;
    localparam int LANE_WIDTH    = 40;
    localparam int TILE_HEIGHT   = 30;
    localparam int NUM_LANES     = 4;
    localparam int NUM_ROWS      = 5;
    localparam int HITBOX_TOP    = 100;
    localparam int HITBOX_BOTTOM = 110;

    localparam logic [2:0] COLOUR_BLACK = 3'b000;
    localparam logic [2:0] COLOUR_BLUE  = 3'b001;
    localparam logic [2:0] COLOUR_GREEN = 3'b010;
    localparam logic [2:0] COLOUR_RED   = 3'b100;
    localparam logic [2:0] COLOUR_WHITE = 3'b111;

    typedef enum logic [1:0] {
        IDLE,
        DRAW,
        FLUSH,
        DONE
    } render_state_t;

    typedef struct packed {
        logic [8:0]  yoffset;
        logic [19:0] keys;
        logic [1:0]  num_hit;
    } snapshot_t;

endpackage

// File: rtl/tile_colour_lookup.sv
// Combinational colour of one playfield pixel given the frame snapshot.
// Priority: covered tile, lane divider, hitbox band, background.
module tile_colour_lookup
    import piano_tiles_pkg::*;
#(
    parameter int LANE_W     = LANE_WIDTH,
    parameter int KEY_HEIGHT = TILE_HEIGHT
) (
    input  logic [7:0] px,
    input  logic [6:0] py,
    input  snapshot_t  snap,
    output logic [2:0] colour
);

    localparam logic [7:0] DIV1 = 8'(LANE_W);
    localparam logic [7:0] DIV2 = 8'(2 * LANE_W);
    localparam logic [7:0] DIV3 = 8'(3 * LANE_W);
    localparam logic [6:0] HB_TOP = 7'(HITBOX_TOP);
    localparam logic [6:0] HB_BOT = 7'(HITBOX_BOTTOM);
    localparam logic signed [10:0] TILE_SPAN = 11'(KEY_HEIGHT);

    logic [1:0]              lane;
    logic signed [10:0]      py_s;
    logic signed [10:0]      row_top [NUM_ROWS];
    logic [NUM_ROWS-1:0]     covered;

    always_comb begin
        if (px < DIV1)      lane = 2'd0;
        else if (px < DIV2) lane = 2'd1;
        else if (px < DIV3) lane = 2'd2;
        else                lane = 2'd3;
    end

    // One spare bit over the 10-bit row math keeps top+height from wrapping near yoffset=511.
    always_comb begin
        py_s = $signed({4'b0000, py});
        for (int r = 0; r < NUM_ROWS; r++) begin
            row_top[r] = $signed({2'b00, snap.yoffset}) - $signed(11'(KEY_HEIGHT * r));
            covered[r] = (py_s >= row_top[r]) && (py_s < row_top[r] + TILE_SPAN)
                         && snap.keys[5'(NUM_LANES * r) + {3'b000, lane}];
        end
    end

    always_comb begin
        colour = COLOUR_WHITE;
        if (py >= HB_TOP && py < HB_BOT) colour = COLOUR_RED;
        if (px == DIV1 || px == DIV2 || px == DIV3) colour = COLOUR_GREEN;
        for (int r = 0; r < NUM_ROWS; r++) begin
            if (covered[r]) colour = (3'(r) < {1'b0, snap.num_hit}) ? COLOUR_BLUE : COLOUR_BLACK;
        end
    end

endmodule

// File: rtl/tile_renderer.sv
// Rasterises the snapshotted playfield into the VGA adapter, one registered pixel per clock,
// and pulses done when the frame is complete.
module tile_renderer
    import piano_tiles_pkg::*;
#(
    parameter int SCREEN_W   = SCREEN_WIDTH,
    parameter int SCREEN_H   = SCREEN_HEIGHT,
    parameter int LANE_W     = LANE_WIDTH,
    parameter int KEY_HEIGHT = TILE_HEIGHT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [8:0]  yoffset,
    input  logic [19:0] keys,
    input  logic [1:0]  num_hit,
    output logic [7:0]  x,
    output logic [6:0]  y,
    output logic [2:0]  colour,
    output logic        plot,
    output logic        busy,
    output logic        done
);

    localparam logic [7:0] LAST_X = 8'(SCREEN_W - 1);
    localparam logic [6:0] LAST_Y = 7'(SCREEN_H - 1);

    render_state_t state, state_next;
    snapshot_t     snap;
    logic [7:0]    px;
    logic [6:0]    py;
    logic [2:0]    pixel_colour;
    logic          last_pixel;

    assign last_pixel = (px == LAST_X) && (py == LAST_Y);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = DRAW;
            DRAW:    if (last_pixel) state_next = FLUSH;
            FLUSH:   state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Inputs are only captured on frame start so engine updates never tear a frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            snap <= '0;
            px   <= '0;
            py   <= '0;
        end else if (state == IDLE && start) begin
            snap <= '{yoffset: yoffset, keys: keys, num_hit: num_hit};
            px   <= '0;
            py   <= '0;
        end else if (state == DRAW && !last_pixel) begin
            if (px == LAST_X) begin
                px <= '0;
                py <= py + 7'd1;
            end else begin
                px <= px + 8'd1;
            end
        end
    end

    tile_colour_lookup #(
        .LANE_W     (LANE_W),
        .KEY_HEIGHT (KEY_HEIGHT)
    ) u_lookup (
        .px     (px),
        .py     (py),
        .snap   (snap),
        .colour (pixel_colour)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            x      <= '0;
            y      <= '0;
            colour <= COLOUR_BLACK;
            plot   <= 1'b0;
        end else begin
            plot <= (state == DRAW);
            if (state == DRAW) begin
                x      <= px;
                y      <= py;
                colour <= pixel_colour;
            end
        end
    end

    assign busy = (state == DRAW) || (state == FLUSH);
    assign done = (state == DONE);

endmodule

// File: tb/tb_tile_renderer.sv
// Scoreboard bench for tile_renderer: a frame-level reference model queues expected pixels,
// a negedge monitor pops and compares every plot beat and the busy/done/plot timing.
module tb_tile_renderer;

    localparam int W = 160;
    localparam int H = 120;
    localparam int FRAME_BEATS = W * H;
    localparam int FRAME_CYCLES = FRAME_BEATS + 2;

    typedef struct {
        int         px;
        int         py;
        logic [2:0] c;
    } pix_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [8:0]  yoffset;
    logic [19:0] keys;
    logic [1:0]  num_hit;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  colour;
    logic        plot;
    logic        busy;
    logic        done;

    pix_t       exp_q[$];
    logic [2:0] fb [FRAME_BEATS];
    int         tests = 0;
    int         fails = 0;
    int         cnt = 0;
    bit         mon_on = 0;
    int         beats = 0;
    int         last_beats = 0;
    int         done_count = 0;
    int         max_y = 0;

    tile_renderer dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .yoffset (yoffset),
        .keys    (keys),
        .num_hit (num_hit),
        .x       (x),
        .y       (y),
        .colour  (colour),
        .plot    (plot),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] ref_colour(int px, int py, int yoff, logic [19:0] k, int nh);
        int lane;
        int top;
        lane = px / 40;
        for (int r = 0; r < 5; r++) begin
            top = yoff - 30 * r;
            if (py >= top && py < top + 30 && k[4 * r + lane])
                return (r < nh) ? 3'b001 : 3'b000;
        end
        if (px == 40 || px == 80 || px == 120) return 3'b010;
        if (py >= 100 && py < 110) return 3'b100;
        return 3'b111;
    endfunction

    function automatic logic [19:0] rand_keys();
        logic [19:0] k;
        k = '0;
        for (int r = 0; r < 5; r++) k[4 * r + int'($urandom_range(0, 3))] = 1'b1;
        return k;
    endfunction

    task automatic push_frame(int yoff, logic [19:0] k, int nh);
        pix_t p;
        for (int py = 0; py < H; py++) begin
            for (int px = 0; px < W; px++) begin
                p.px = px;
                p.py = py;
                p.c  = ref_colour(px, py, yoff, k, nh);
                exp_q.push_back(p);
            end
        end
    endtask

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_fb();
        for (int i = 0; i < FRAME_BEATS; i++) fb[i] = 3'bxxx;
        max_y = 0;
    endtask

    task automatic wait_done(string name);
        int dc;
        int n;
        dc = done_count;
        n = 0;
        while (done_count == dc && n < FRAME_CYCLES + 100) begin
            @(posedge clk);
            n++;
        end
        if (done_count == dc) begin
            tests++;
            fails++;
            $display("[TB] FAIL %s: done not seen within %0d cycles", name, n);
        end
    endtask

    // Frame-level model: accepts start only when idle, then stays busy for a fixed frame length.
    initial begin
        forever begin
            @(posedge clk);
            if (reset) begin
                cnt = 0;
                exp_q.delete();
            end else if (cnt == 0 && start) begin
                push_frame(int'(yoffset), keys, int'(num_hit));
                cnt = FRAME_CYCLES;
            end else if (cnt > 0) begin
                cnt--;
            end
        end
    end

    initial begin
        pix_t e;
        logic pe, be, de;
        forever begin
            @(negedge clk);
            if (mon_on) begin
                pe = (cnt >= 2) && (cnt <= FRAME_BEATS + 1);
                be = (cnt >= 2);
                de = (cnt == 1);
                check("ctrl_plot_busy_done", {29'd0, plot, busy, done}, {29'd0, pe, be, de});
                if (plot === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("[TB] FAIL unexpected_plot: got (%0d,%0d) expected none", x, y);
                    end else begin
                        e = exp_q.pop_front();
                        check("pixel", {14'd0, x, y, colour},
                              {14'd0, 8'(e.px), 7'(e.py), e.c});
                    end
                    if (int'(x) < W && int'(y) < H) fb[int'(y) * W + int'(x)] = colour;
                    if (int'(y) > max_y) max_y = int'(y);
                    beats++;
                end
                if (done === 1'b1) begin
                    last_beats = beats;
                    beats = 0;
                    done_count++;
                end
                if (reset === 1'b1) beats = 0;
            end
        end
    end

    function automatic logic [2:0] pix(int px, int py);
        return fb[py * W + px];
    endfunction

    initial begin
        int dc;
        int n;
        reset = 1'b1;
        start = 1'b0;
        yoffset = '0;
        keys = '0;
        num_hit = '0;
        clear_fb();
        repeat (2) @(posedge clk);
        #1;
        check("reset_x", 32'(x), 0);
        check("reset_y", 32'(y), 0);
        check("reset_colour", 32'(colour), 0);
        check("reset_plot", 32'(plot), 0);
        check("reset_busy", 32'(busy), 0);
        check("reset_done", 32'(done), 0);
        reset = 1'b0;
        mon_on = 1;

        // Frame A: engine inputs scrambled mid-frame must not affect the picture.
        @(posedge clk);
        #1;
        yoffset = 9'd90;
        keys = 20'h84218;
        num_hit = 2'd0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("A_busy_after_start", 32'(busy), 1);
        repeat (100) @(posedge clk);
        #1;
        yoffset = 9'($urandom_range(0, 511));
        keys = rand_keys();
        num_hit = 2'($urandom_range(0, 3));
        wait_done("A_done");
        check("A_beats", 32'(last_beats), FRAME_BEATS);
        check("A_130_95", 32'(pix(130, 95)), 32'(3'b000));
        check("A_10_95", 32'(pix(10, 95)), 32'(3'b111));
        check("A_50_105", 32'(pix(50, 105)), 32'(3'b100));
        check("A_40_10", 32'(pix(40, 10)), 32'(3'b010));

        // Frames B1/B2: start held high through a frame, second frame runs back-to-back.
        clear_fb();
        #1;
        yoffset = 9'd90;
        keys = 20'h84218;
        num_hit = 2'd1;
        start = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        yoffset = 9'd120;
        keys = 20'hF0000;
        wait_done("B1_done");
        check("B1_beats", 32'(last_beats), FRAME_BEATS);
        check("B1_130_95", 32'(pix(130, 95)), 32'(3'b001));
        check("B1_20_70", 32'(pix(20, 70)), 32'(3'b000));
        clear_fb();
        @(posedge clk);
        #1;
        start = 1'b0;
        check("B2_back_to_back_busy", 32'(busy), 1);
        wait_done("B2_done");
        check("B2_beats", 32'(last_beats), FRAME_BEATS);
        check("B2_5_0", 32'(pix(5, 0)), 32'(3'b000));
        check("B2_159_29", 32'(pix(159, 29)), 32'(3'b000));
        check("B2_5_30", 32'(pix(5, 30)), 32'(3'b111));
        check("B2_max_y", 32'(max_y), 119);
        dc = done_count;
        repeat (5) @(posedge clk);
        check("B_single_done", 32'(done_count), 32'(dc));

        // Frame C: reset asserted part-way through the frame.
        #1;
        yoffset = 9'($urandom_range(0, 511));
        keys = rand_keys();
        num_hit = 2'($urandom_range(0, 3));
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        dc = done_count;
        n = 0;
        while (beats < 5000 && n < 6000) begin
            @(posedge clk);
            n++;
        end
        check("C_reached_5000", 32'(beats >= 5000), 1);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("C_plot_after_reset", 32'(plot), 0);
        check("C_busy_after_reset", 32'(busy), 0);
        repeat (50) @(posedge clk);
        check("C_no_done", 32'(done_count), 32'(dc));

        // Frame D: random snapshot, inputs re-randomised mid-frame.
        clear_fb();
        #1;
        yoffset = 9'($urandom_range(0, 511));
        keys = rand_keys();
        num_hit = 2'($urandom_range(0, 3));
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3000) @(posedge clk);
        #1;
        yoffset = 9'($urandom_range(0, 511));
        keys = rand_keys();
        num_hit = 2'($urandom_range(0, 3));
        wait_done("D_done");
        check("D_beats", 32'(last_beats), FRAME_BEATS);
        repeat (3) @(posedge clk);
        check("D_queue_empty", 32'(exp_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
